// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Two-requester write arbiter in front of a register file, with a
//   full-file clear sweep. Requests are arbitrated round-robin: a lone
//   valid requester wins, and under contention the requester that did not
//   win last time wins. The register-file write port is registered, so an
//   accepted write appears on write_reg/w_addr/w_data the cycle after the
//   handshake. A clr_start pulse, when the arbiter is idle in ARB, starts a
//   sweep that writes zero to every address 0..NUM_REGS-1 on consecutive
//   cycles. No request is accepted during the sweep.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   reqN_valid          requester N has a write pending (N = 0, 1)
//   reqN_addr/reqN_data requester N target address / write data
//   reqN_ready          requester N is accepted this cycle if valid
//   clr_start           single-cycle pulse requesting a full clear
//   clr_busy            clear sweep in progress
//   write_reg           register-file write enable
//   w_addr/w_data       register-file write address / data
//   last_grant          ID of the most recently accepted requester
module reg_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              write_reg,
  output logic [ADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0] w_data,
  output logic              last_grant
);

  // One spare bit so the counter can never wrap inside a sweep.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_REGS - 1);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              write_reg_q, write_reg_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic              clr_busy_q, clr_busy_d;
  logic              grant0, grant1;

  // Grant decode. clr_start pre-empts any request in the same cycle, and
  // both readies are forced low while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ARB && !clr_start && reset) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    write_reg_d  = 1'b0;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    clr_busy_d   = clr_busy_q;
    case (state_q)
      ARB: begin
        if (clr_start) begin
          // The first clear write (address 0) is loaded on the entry edge,
          // so the counter always names the address currently on w_addr.
          state_d     = CLEAR;
          cnt_d       = '0;
          write_reg_d = 1'b1;
          w_addr_d    = '0;
          w_data_d    = '0;
          clr_busy_d  = 1'b1;
        end else if (grant0) begin
          last_grant_d = 1'b0;
          write_reg_d  = 1'b1;
          w_addr_d     = req0_addr;
          w_data_d     = req0_data;
        end else if (grant1) begin
          last_grant_d = 1'b1;
          write_reg_d  = 1'b1;
          w_addr_d     = req1_addr;
          w_data_d     = req1_data;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          // Last clear write is on the outputs now; the next cycle is ARB
          // with no write, so a waiting request lands one cycle later.
          state_d    = ARB;
          clr_busy_d = 1'b0;
        end else begin
          cnt_d       = cnt_q + 1'b1;
          write_reg_d = 1'b1;
          w_addr_d    = ADDR_W'(cnt_q + 1'b1);
          w_data_d    = '0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      write_reg_q  <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      clr_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      write_reg_q  <= write_reg_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      clr_busy_q   <= clr_busy_d;
    end
  end

  assign clr_busy   = clr_busy_q;
  assign write_reg  = write_reg_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign last_grant = last_grant_q;

endmodule
